// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side request/data lanes and RAM-side command/response
// signals of the three-port RAM arbiter.
interface ram_port_arbiter_if #(
    parameter int WL = 96,
    parameter int ADDRW = 9
);
    logic [2:0] iREQ, iWE, iLAST;
    logic [3*ADDRW-1:0] iADDR;
    logic [3*WL-1:0] iWDATA;
    logic [2:0] oGNT;
    logic [ADDRW-1:0] oRAM_ADDR;
    logic [WL-1:0] oRAM_DATA;
    logic oRAM_WREN, oRAM_RDEN, oRVALID, oBUSY;
    logic [1:0] oRID;
    modport master (
        output iREQ, iWE, iLAST, iADDR, iWDATA,
        input oGNT, oRAM_ADDR, oRAM_DATA, oRAM_WREN, oRAM_RDEN, oRVALID, oRID, oBUSY
    );
    modport slave (
        input iREQ, iWE, iLAST, iADDR, iWDATA,
        output oGNT, oRAM_ADDR, oRAM_DATA, oRAM_WREN, oRAM_RDEN, oRVALID, oRID, oBUSY
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: grants one of three requesters burst access to a single-port RAM with a
// read-to-write turnaround cycle; define RAM_ARB_RR_EN for round-robin, else fixed priority 0>1>2.
module ram_port_arbiter #(
    parameter int WL = 96,
    parameter int ADDRW = 9,
    parameter int MAXBURST = 64
) (
    input logic iCLK,
    input logic iRST,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
    state_t state, state_n;
    logic [1:0] own, win, rid_q;
    logic [7:0] cnt;
    logic last_rd, acc, rel, turn, any, newg, we_own;

    assign any = |bus.iREQ;
    assign we_own = bus.iWE[own];
    assign acc = state == GRANT && bus.iREQ[own];
    assign rel = state == GRANT && (!bus.iREQ[own] || bus.iLAST[own] || {1'b0, cnt} + 9'd1 == 9'(MAXBURST));
    // a burst ending in a read must not hand the port straight to a writer
    assign turn = (acc ? !we_own : last_rd) && |(bus.iREQ & bus.iWE);
    assign newg = any && (state != GRANT || (rel && !turn));

`ifdef RAM_ARB_RR_EN
    logic [1:0] ptr, p1, p2;
    assign p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    assign p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    assign win = bus.iREQ[p1] ? p1 : bus.iREQ[p2] ? p2 : ptr;
    always_ff @(posedge iCLK)
        if (iRST) ptr <= 2'd0;
        else if (newg) ptr <= win;
`else
    assign win = bus.iREQ[0] ? 2'd0 : bus.iREQ[1] ? 2'd1 : 2'd2;
`endif

    always_ff @(posedge iCLK)
        if (iRST) begin
            state <= IDLE;
            own <= 2'd0;
            cnt <= 8'd0;
            last_rd <= 1'b0;
        end else begin
            state <= state_n;
            if (newg) begin
                own <= win;
                cnt <= 8'd0;
                last_rd <= 1'b0;
            end else if (acc) begin
                cnt <= cnt + 8'd1;
                last_rd <= !we_own;
            end
        end

    always_comb
        state_n = state != GRANT ? (any ? GRANT : IDLE) : !rel ? GRANT : turn ? TURN : any ? GRANT : IDLE;

    always_comb begin
        bus.oGNT = state == GRANT ? 3'b001 << own : 3'b000;
        bus.oBUSY = state != IDLE;
    end

    always_ff @(posedge iCLK)
        if (iRST) begin
            bus.oRAM_ADDR <= '0;
            bus.oRAM_DATA <= '0;
            bus.oRAM_WREN <= 1'b0;
            bus.oRAM_RDEN <= 1'b0;
            bus.oRVALID <= 1'b0;
            bus.oRID <= 2'd0;
            rid_q <= 2'd0;
        end else begin
            bus.oRAM_ADDR <= acc ? bus.iADDR[own*ADDRW +: ADDRW] : '0;
            bus.oRAM_DATA <= acc ? bus.iWDATA[own*WL +: WL] : '0;
            bus.oRAM_WREN <= acc && we_own;
            bus.oRAM_RDEN <= acc && !we_own;
            bus.oRVALID <= bus.oRAM_RDEN;
            bus.oRID <= bus.oRAM_RDEN ? rid_q : 2'd0;
            if (acc) rid_q <= own;
        end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven checks of ram_port_arbiter (MAXBURST=4) plus burst-limit,
// turnaround and mid-burst reset sequences; follows RAM_ARB_RR_EN if defined.
module tb_ram_port_arbiter;
    localparam int WL = 16;
    localparam int ADDRW = 9;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    ram_port_arbiter_if #(.WL(WL), .ADDRW(ADDRW)) bus ();
    ram_port_arbiter #(.WL(WL), .ADDRW(ADDRW), .MAXBURST(4)) dut (.iCLK(clk), .iRST(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic [2:0] req, we, last;
        logic [8:0] a0, a1, a2;
        logic [2:0] gnt;
        logic wren, rden;
        logic [8:0] addr;
        logic rvalid;
        logic [1:0] rid;
        logic busy;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic [2:0] req, we, last, input logic [8:0] a0, a1, a2,
                               input logic [2:0] gnt, input logic wren, rden, input logic [8:0] addr,
                               input logic rvalid, input logic [1:0] rid, input logic busy);
        vec_t t;
        t.rst = r; t.req = req; t.we = we; t.last = last; t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.gnt = gnt; t.wren = wren; t.rden = rden; t.addr = addr; t.rvalid = rvalid; t.rid = rid; t.busy = busy;
        return t;
    endfunction

    function automatic int w(input int k);
        return RR ? (k + 1) % 3 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rz, input logic [2:0] gnt, input logic wren, rden,
                             input logic [8:0] addr, input logic rvalid, input logic [1:0] rid, input logic busy);
        chk({tag, ".gnt"}, 32'(bus.oGNT), 32'(gnt));
        chk({tag, ".wren"}, 32'(bus.oRAM_WREN), 32'(wren));
        chk({tag, ".rden"}, 32'(bus.oRAM_RDEN), 32'(rden));
        chk({tag, ".rvalid"}, 32'(bus.oRVALID), 32'(rvalid));
        chk({tag, ".busy"}, 32'(bus.oBUSY), 32'(busy));
        if (rvalid || rz) chk({tag, ".rid"}, 32'(bus.oRID), 32'(rid));
        if (wren || rden || rz) begin
            chk({tag, ".addr"}, 32'(bus.oRAM_ADDR), 32'(addr));
            chk({tag, ".data"}, 32'(bus.oRAM_DATA), rz ? 32'd0 : 32'(16'hA000 | 16'(addr)));
        end
    endtask

    task automatic drive(input logic [2:0] req, we, last, input logic [8:0] a0, a1, a2);
        bus.iREQ = req;
        bus.iWE = we;
        bus.iLAST = last;
        bus.iADDR = {a2, a1, a0};
        bus.iWDATA = {16'hA000 | 16'(a2), 16'hA000 | 16'(a1), 16'hA000 | 16'(a0)};
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0);
        // reset, then requester 0 writes 0..3 with iLAST on the fourth
        vecs.push_back(v(1, 3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0));
        vecs.push_back(v(0, 3'b001, 3'b001, 3'b000, 9'h0, 9'h0, 9'h0, 3'b001, 0, 0, 9'h0, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b001, 3'b001, 3'b000, 9'h0, 9'h0, 9'h0, 3'b001, 1, 0, 9'h0, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b001, 3'b001, 3'b000, 9'h1, 9'h0, 9'h0, 3'b001, 1, 0, 9'h1, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b001, 3'b001, 3'b000, 9'h2, 9'h0, 9'h0, 3'b001, 1, 0, 9'h2, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b001, 3'b001, 3'b001, 9'h3, 9'h0, 9'h0, 3'b001, 1, 0, 9'h3, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0));
        // requester 1 single read of 0x25: RDEN one cycle after accept, RVALID/RID one cycle later
        vecs.push_back(v(0, 3'b010, 3'b000, 3'b010, 9'h0, 9'h25, 9'h0, 3'b010, 0, 0, 9'h0, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b010, 3'b000, 3'b010, 9'h0, 9'h25, 9'h0, 3'b010, 0, 1, 9'h25, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 0, 0, 9'h0, 1, 2'd1, 0));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0));
        // requester 1 read burst ends while requester 2 waits to write: one TURN cycle
        vecs.push_back(v(0, 3'b010, 3'b000, 3'b000, 9'h0, 9'h26, 9'h0, 3'b010, 0, 0, 9'h0, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b110, 3'b100, 3'b000, 9'h0, 9'h26, 9'h40, 3'b010, 0, 1, 9'h26, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b110, 3'b100, 3'b010, 9'h0, 9'h27, 9'h40, 3'b000, 0, 1, 9'h27, 1, 2'd1, 1));
        vecs.push_back(v(0, 3'b100, 3'b100, 3'b000, 9'h0, 9'h0, 9'h40, 3'b100, 0, 0, 9'h0, 1, 2'd1, 1));
        vecs.push_back(v(0, 3'b100, 3'b100, 3'b100, 9'h0, 9'h0, 9'h40, 3'b100, 1, 0, 9'h40, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0));
        // reset with all requesting, then single-access bursts from all three
        vecs.push_back(v(1, 3'b111, 3'b111, 3'b111, 9'h08, 9'h28, 9'h48, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0));
        for (int i = 1; i <= 6; i++)
            vecs.push_back(v(0, 3'b111, 3'b111, 3'b111, 9'h08, 9'h28, 9'h48, 3'(1 << w(i - 1)), i >= 2, 0,
                             i >= 2 ? 9'(8 + 32 * w(i - 2)) : 9'h0, 0, 2'd0, 1));
        vecs.push_back(v(0, 3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            drive(vecs[i].req, vecs[i].we, vecs[i].last, vecs[i].a0, vecs[i].a1, vecs[i].a2);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].rst, vecs[i].gnt, vecs[i].wren, vecs[i].rden,
                      vecs[i].addr, vecs[i].rvalid, vecs[i].rid, vecs[i].busy);
        end

        // ten streamed writes without iLAST: 4-access grants re-issued back to back
        rst = 1'b0;
        drive(3'b001, 3'b001, 3'b000, 9'h10, 9'h0, 9'h0);
        step();
        check_out("wstream.grant", 0, 3'b001, 0, 0, 9'h0, 0, 2'd0, 1);
        for (int j = 1; j <= 10; j++) begin
            drive(3'b001, 3'b001, 3'b000, 9'(16 + j - 1), 9'h0, 9'h0);
            step();
            check_out($sformatf("wstream%0d", j), 0, 3'b001, 1, 0, 9'(16 + j - 1), 0, 2'd0, 1);
        end
        drive(3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0);
        step();
        check_out("wstream.end", 0, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0);

        // streamed reads hit the 4-access limit while requester 2 waits to write
        drive(3'b001, 3'b000, 3'b000, 9'h60, 9'h0, 9'h70);
        step();
        check_out("rstream.grant", 0, 3'b001, 0, 0, 9'h0, 0, 2'd0, 1);
        for (int j = 1; j <= 4; j++) begin
            drive(3'b101, 3'b100, 3'b000, 9'(96 + j - 1), 9'h0, 9'h70);
            step();
            check_out($sformatf("rstream%0d", j), 0, j < 4 ? 3'b001 : 3'b000, 0, 1, 9'(96 + j - 1), j > 1, 2'd0, 1);
        end
        drive(3'b101, 3'b100, 3'b000, 9'h64, 9'h0, 9'h70);
        step();
        check_out("rstream.regrant", 0, RR ? 3'b100 : 3'b001, 0, 0, 9'h0, 1, 2'd0, 1);
        step();
        check_out("rstream.next", 0, RR ? 3'b100 : 3'b001, RR, !RR, RR ? 9'h70 : 9'h64, 0, 2'd0, 1);
        rst = 1'b1;
        step();
        check_out("midreset", 1, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0);
        rst = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 9'h0, 9'h0, 9'h0);
        step();
        check_out("postreset", 0, 3'b000, 0, 0, 9'h0, 0, 2'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
